// File: rtl/delta_calc_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : delta_calc_scheduler
// Purpose  : Round-robin sharing of one delta calculator among four wheel channels
// Revision : 1.0
// =============================================================================
module delta_calc_scheduler (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  req,
   input  logic [47:0] target_bus,
   input  logic [47:0] current_bus,
   output logic        calc_enable,
   output logic [11:0] calc_target,
   output logic [11:0] calc_current,
   input  logic        calc_dir,
   input  logic [11:0] calc_delta,
   input  logic        calc_done,
   output logic [3:0]  grant,
   output logic [47:0] delta_bus,
   output logic [3:0]  dir_bus,
   output logic [3:0]  done,
   output logic [3:0]  timeout,
   output logic        busy
);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_LAUNCH = 2'd1;
   localparam logic [1:0] c_ST_WAIT   = 2'd2;
   localparam logic [4:0] c_CNT_LAST  = 5'd31;

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic [1:0]  r_ptr;
   logic [1:0]  r_idx;
   logic [4:0]  r_cnt;
   logic [3:0]  r_grant;
   logic [11:0] r_target;
   logic [11:0] r_current;
   logic [47:0] r_delta;
   logic [3:0]  r_dir;
   logic [3:0]  r_done;
   logic [3:0]  r_timeout;
   logic        w_found;
   logic [1:0]  w_sel_idx;
   logic [1:0]  w_cand;

   // First requesting channel at or after ptr, wrapping modulo 4.
   always_comb begin
      w_found   = 1'b0;
      w_sel_idx = r_ptr;
      w_cand    = r_ptr;
      for (int i = 0; i < 4; i++) begin
         w_cand = r_ptr + 2'(i);
         if (!w_found && req[w_cand]) begin
            w_found   = 1'b1;
            w_sel_idx = w_cand;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= c_ST_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE:   if (w_found) w_next_state = c_ST_LAUNCH;
         c_ST_LAUNCH: w_next_state = c_ST_WAIT;
         c_ST_WAIT:   if (calc_done || (r_cnt == c_CNT_LAST)) w_next_state = c_ST_IDLE;
         default:     w_next_state = c_ST_IDLE;
      endcase
   end

   always_comb begin
      calc_enable = (r_state == c_ST_LAUNCH);
      busy        = (r_state != c_ST_IDLE);
   end

   // A result arriving on the terminal count wins over the timeout.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr     <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_grant   <= '0;
         r_target  <= '0;
         r_current <= '0;
         r_delta   <= '0;
         r_dir     <= '0;
         r_done    <= '0;
         r_timeout <= '0;
      end else begin
         r_done    <= '0;
         r_timeout <= '0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_found) begin
                  r_idx     <= w_sel_idx;
                  r_grant   <= 4'b0001 << w_sel_idx;
                  r_target  <= target_bus[w_sel_idx*12 +: 12];
                  r_current <= current_bus[w_sel_idx*12 +: 12];
               end
            end
            c_ST_LAUNCH: r_cnt <= '0;
            c_ST_WAIT: begin
               if (calc_done) begin
                  r_delta[r_idx*12 +: 12] <= calc_delta;
                  r_dir[r_idx]            <= calc_dir;
                  r_done[r_idx]           <= 1'b1;
                  r_grant                 <= '0;
                  r_ptr                   <= r_idx + 2'd1;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_timeout[r_idx] <= 1'b1;
                  r_grant          <= '0;
                  r_ptr            <= r_idx + 2'd1;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant        = r_grant;
   assign calc_target  = r_target;
   assign calc_current = r_current;
   assign delta_bus    = r_delta;
   assign dir_bus      = r_dir;
   assign done         = r_done;
   assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_delta_calc_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_delta_calc_scheduler
// Purpose  : Self-checking bench with calculator model and result scoreboard
// Revision : 1.0
// =============================================================================
module tb_delta_calc_scheduler;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [47:0] target_bus;
   logic [47:0] current_bus;
   logic        calc_enable;
   logic [11:0] calc_target;
   logic [11:0] calc_current;
   logic        calc_dir;
   logic [11:0] calc_delta;
   logic        calc_done;
   logic [3:0]  grant;
   logic [47:0] delta_bus;
   logic [3:0]  dir_bus;
   logic [3:0]  done;
   logic [3:0]  timeout;
   logic        busy;

   delta_calc_scheduler dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req          (req),
      .target_bus   (target_bus),
      .current_bus  (current_bus),
      .calc_enable  (calc_enable),
      .calc_target  (calc_target),
      .calc_current (calc_current),
      .calc_dir     (calc_dir),
      .calc_delta   (calc_delta),
      .calc_done    (calc_done),
      .grant        (grant),
      .delta_bus    (delta_bus),
      .dir_bus      (dir_bus),
      .done         (done),
      .timeout      (timeout),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          ch;
      logic [11:0] tgt;
      logic [11:0] cur;
      int          lat;
      bit          tmo;
      logic [11:0] delta;
      logic        dir;
   } vec_t;

   typedef struct {
      int          ch;
      bit          tmo;
      logic [11:0] delta;
      logic        dir;
   } exp_t;

   int   n_pass   = 0;
   int   n_checks = 0;
   int   model_lat = 2;
   int   cyc = 0;
   int   launch_cyc = 0;
   int   done_seen = 0;
   exp_t sb[$];
   logic [47:0] shadow_delta;
   logic [3:0]  shadow_dir;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   // Shortest signed distance from current to target on a 4096-point wheel.
   function automatic void calc_fn(input logic [11:0] t, input logic [11:0] c,
                                   output logic [11:0] d, output logic r);
      logic [11:0] diff;
      diff = t - c;
      if (diff <= 12'd2048) begin d = diff;  r = 1'b0; end
      else                  begin d = c - t; r = 1'b1; end
   endfunction

   task automatic push_exp(input int ch, input bit tmo, input logic [11:0] t, input logic [11:0] c);
      exp_t e;
      e.ch  = ch;
      e.tmo = tmo;
      calc_fn(t, c, e.delta, e.dir);
      sb.push_back(e);
   endtask

   task automatic set_chan(input int ch, input logic [11:0] t, input logic [11:0] c);
      target_bus[ch*12 +: 12]  = t;
      current_bus[ch*12 +: 12] = c;
   endtask

   task automatic wait_launch(input logic [3:0] g, input logic [11:0] t, input logic [11:0] c);
      int k;
      k = 0;
      do begin @(negedge clock); k++; end while (!calc_enable && k < 80);
      check("launch_seen", {47'd0, calc_enable}, 48'd1);
      check("grant", {44'd0, grant}, {44'd0, g});
      check("calc_target", {36'd0, calc_target}, {36'd0, t});
      check("calc_current", {36'd0, calc_current}, {36'd0, c});
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin @(negedge clock); k++; end while (busy && k < 80);
      check("idle_reached", {47'd0, busy}, 48'd0);
   endtask

   // Shared calculator model: answers from the operands the DUT presents.
   initial begin
      logic [11:0] d;
      logic        r;
      calc_done  = 1'b0;
      calc_delta = '0;
      calc_dir   = 1'b0;
      forever begin
         @(negedge clock);
         if (reset_n && calc_enable && model_lat >= 0) begin
            calc_fn(calc_target, calc_current, d, r);
            repeat (model_lat) @(negedge clock);
            calc_done  = 1'b1;
            calc_delta = d;
            calc_dir   = r;
            @(negedge clock);
            calc_done  = 1'b0;
         end
      end
   end

   always @(negedge clock) begin : mon
      exp_t e;
      cyc++;
      if (!reset_n) begin
         shadow_delta = '0;
         shadow_dir   = '0;
         check("rst_outputs", {calc_enable, busy, grant, done, timeout, dir_bus, calc_target, calc_current},
               48'd0);
         check("rst_delta_bus", delta_bus, 48'd0);
      end else begin
         if (calc_enable) launch_cyc = cyc;
         if ((done | timeout) != 4'd0) begin
            if (done != 4'd0) done_seen++;
            if (sb.size() == 0) begin
               check("unexpected_out", {40'd0, done, timeout}, 48'd0);
            end else begin
               e = sb.pop_front();
               check("out_chan", {44'd0, done | timeout}, {44'd0, 4'b0001 << e.ch});
               check("out_kind", {47'd0, timeout != 4'd0}, {47'd0, e.tmo});
               check("busy_after_out", {47'd0, busy}, 48'd0);
               if (e.tmo) check("timeout_latency", 48'(cyc - launch_cyc), 48'd33);
               else begin
                  shadow_delta[e.ch*12 +: 12] = e.delta;
                  shadow_dir[e.ch]            = e.dir;
               end
            end
         end
         check("delta_bus", delta_bus, shadow_delta);
         check("dir_bus", {44'd0, dir_bus}, {44'd0, shadow_dir});
         check("onehot", {45'd0, $onehot0(grant), $onehot0(done), $onehot0(timeout)}, 48'd7);
      end
   end

   initial begin
      vec_t vecs[7];
      int   d0;
      vecs[0] = '{0, 12'd100,  12'd4000, 7,  1'b0, 12'd196,  1'b0};
      vecs[1] = '{1, 12'd4000, 12'd100,  5,  1'b0, 12'd196,  1'b1};
      vecs[2] = '{2, 12'd0,    12'd0,    1,  1'b0, 12'd0,    1'b0};
      vecs[3] = '{3, 12'd2048, 12'd0,    3,  1'b0, 12'd2048, 1'b0};
      vecs[4] = '{1, 12'd1000, 12'd3000, 20, 1'b0, 12'd2000, 1'b1};
      vecs[5] = '{2, 12'd4095, 12'd0,    32, 1'b0, 12'd1,    1'b1};
      vecs[6] = '{0, 12'd5,    12'd10,   33, 1'b1, 12'd0,    1'b0};

      reset_n     = 1'b0;
      req         = 4'b1111;
      target_bus  = '0;
      current_bus = '0;
      set_chan(0, 12'd10,   12'd20);
      set_chan(1, 12'd300,  12'd100);
      set_chan(2, 12'd50,   12'd4050);
      set_chan(3, 12'd3000, 12'd900);
      repeat (3) @(negedge clock);
      check("reset_busy", {47'd0, busy}, 48'd0);
      check("reset_grant", {44'd0, grant}, 48'd0);

      // All channels requesting from reset: strict rotation, ch0 served twice.
      model_lat = 2;
      push_exp(0, 1'b0, 12'd10,   12'd20);
      push_exp(1, 1'b0, 12'd300,  12'd100);
      push_exp(2, 1'b0, 12'd50,   12'd4050);
      push_exp(3, 1'b0, 12'd3000, 12'd900);
      push_exp(0, 1'b0, 12'd10,   12'd20);
      @(posedge clock); #1 reset_n = 1'b1;
      wait_launch(4'b0001, 12'd10,   12'd20);
      wait_launch(4'b0010, 12'd300,  12'd100);
      wait_launch(4'b0100, 12'd50,   12'd4050);
      wait_launch(4'b1000, 12'd3000, 12'd900);
      wait_launch(4'b0001, 12'd10,   12'd20);
      req = 4'b0000;
      wait_idle();
      repeat (4) @(negedge clock);

      // Single-request table; req dropped during LAUNCH must not abort.
      for (int i = 0; i < 7; i++) begin
         exp_t e;
         set_chan(vecs[i].ch, vecs[i].tgt, vecs[i].cur);
         model_lat = vecs[i].lat;
         e.ch = vecs[i].ch; e.tmo = vecs[i].tmo; e.delta = vecs[i].delta; e.dir = vecs[i].dir;
         sb.push_back(e);
         req = 4'b0001 << vecs[i].ch;
         wait_launch(4'b0001 << vecs[i].ch, vecs[i].tgt, vecs[i].cur);
         req = 4'b0000;
         wait_idle();
         repeat (4) @(negedge clock);
      end

      // Silent calculator: both channels time out, ch1 first since ch0 was last.
      model_lat = -1;
      set_chan(0, 12'd11, 12'd22);
      set_chan(1, 12'd33, 12'd44);
      push_exp(1, 1'b1, 12'd33, 12'd44);
      push_exp(0, 1'b1, 12'd11, 12'd22);
      req = 4'b0011;
      wait_launch(4'b0010, 12'd33, 12'd44);
      wait_launch(4'b0001, 12'd11, 12'd22);
      req = 4'b0000;
      wait_idle();
      repeat (4) @(negedge clock);

      // Operand stability while current_bus churns.
      model_lat = 12;
      set_chan(1, 12'd1234, 12'd567);
      push_exp(1, 1'b0, 12'd1234, 12'd567);
      req = 4'b0010;
      wait_launch(4'b0010, 12'd1234, 12'd567);
      req = 4'b0000;
      begin
         int k;
         k = 0;
         while (busy && k < 40) begin
            current_bus = {16'($urandom), 32'($urandom)};
            @(negedge clock);
            k++;
            check("stable_current", {36'd0, calc_current}, 48'd567);
            check("stable_target", {36'd0, calc_target}, 48'd1234);
         end
      end
      current_bus = '0;
      repeat (4) @(negedge clock);

      // Reset mid-WAIT: no result, late calc_done ignored, rotation restarts at ch0.
      model_lat = 10;
      set_chan(2, 12'd700, 12'd200);
      req = 4'b0100;
      wait_launch(4'b0100, 12'd700, 12'd200);
      req = 4'b0000;
      d0 = done_seen;
      repeat (3) @(negedge clock);
      @(posedge clock); #1 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (14) @(negedge clock);
      check("no_done_after_reset", 48'(done_seen), 48'(d0));
      check("idle_after_reset", {43'd0, busy, grant}, 48'd0);
      model_lat = 2;
      set_chan(0, 12'd77, 12'd4090);
      set_chan(1, 12'd1, 12'd2);
      set_chan(2, 12'd3, 12'd4);
      set_chan(3, 12'd5, 12'd6);
      push_exp(0, 1'b0, 12'd77, 12'd4090);
      req = 4'b1111;
      wait_launch(4'b0001, 12'd77, 12'd4090);
      req = 4'b0000;
      wait_idle();
      repeat (4) @(negedge clock);

      check("scoreboard_empty", 48'(sb.size()), 48'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
